// File: rtl/regmem_rr_arbiter.sv
// regmem_rr_arbiter
//   Register memory of DEPTH x DATA_WIDTH shared by two requesters, A and B.
//   A round-robin arbiter picks at most one access per cycle. Each accepted
//   access (read or write) returns a response one cycle later, carrying the
//   entry contents as they were before the access (read-before-write).
//
// Ports
//   clk, rst_n          clock, async active-low reset (sync release expected)
//   a_req_*             A request channel: valid/ready, write, addr, wdata
//   a_rsp_valid/rdata   A response pulse and data (rdata holds between pulses)
//   b_req_*, b_rsp_*    same as A, for requester B
//   last_grant          0 = A granted last, 1 = B granted last
module regmem_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_write,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_rdata,

    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_write,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_rdata,

    output logic                  last_grant
);

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    req_t                  a_req, b_req, sel;
    logic                  grant_a, grant_b, accept;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] old_data;

    assign a_req = '{write: a_req_write, addr: a_req_addr, wdata: a_req_wdata};
    assign b_req = '{write: b_req_write, addr: b_req_addr, wdata: b_req_wdata};

    // Under contention the side that was not granted last wins; a lone
    // requester always wins. Grants are exclusive and imply valid.
    assign grant_a = a_req_valid & (~b_req_valid | last_grant);
    assign grant_b = b_req_valid & (~a_req_valid | ~last_grant);
    assign accept  = grant_a | grant_b;

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;

    assign sel = grant_b ? b_req : a_req;

    // Decode by compare-per-entry: an address with no matching entry
    // (addr >= DEPTH) reads as zero and writes nothing.
    always_comb begin
        old_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel.addr == ADDR_WIDTH'(i)) old_data = mem[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            last_grant  <= 1'b1;
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            a_rsp_rdata <= '0;
            b_rsp_rdata <= '0;
        end else begin
            a_rsp_valid <= grant_a;
            b_rsp_valid <= grant_b;
            if (grant_a) a_rsp_rdata <= old_data;
            if (grant_b) b_rsp_rdata <= old_data;
            if (accept)  last_grant  <= grant_b;
            for (int i = 0; i < DEPTH; i++) begin
                if (accept && sel.write && sel.addr == ADDR_WIDTH'(i))
                    mem[i] <= sel.wdata;
            end
        end
    end

endmodule

// File: tb/tb_regmem_rr_arbiter.sv
// Bench for regmem_rr_arbiter: one default instance (DEPTH=4) and one with
// DEPTH=3 to reach the out-of-range address case. Index d selects the
// instance, s selects the side (0 = A, 1 = B).
module tb_regmem_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       rv [2][2];
    logic       rw [2][2];
    logic [1:0] ra [2][2];
    logic [7:0] rd [2][2];
    logic       rdy[2][2];
    logic       sv [2][2];
    logic [7:0] sd [2][2];
    logic       lg [2];

    regmem_rr_arbiter #(.DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(rv[0][0]), .a_req_ready(rdy[0][0]), .a_req_write(rw[0][0]),
        .a_req_addr(ra[0][0]), .a_req_wdata(rd[0][0]),
        .a_rsp_valid(sv[0][0]), .a_rsp_rdata(sd[0][0]),
        .b_req_valid(rv[0][1]), .b_req_ready(rdy[0][1]), .b_req_write(rw[0][1]),
        .b_req_addr(ra[0][1]), .b_req_wdata(rd[0][1]),
        .b_rsp_valid(sv[0][1]), .b_rsp_rdata(sd[0][1]),
        .last_grant(lg[0])
    );

    regmem_rr_arbiter #(.DATA_WIDTH(8), .DEPTH(3), .ADDR_WIDTH(2)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(rv[1][0]), .a_req_ready(rdy[1][0]), .a_req_write(rw[1][0]),
        .a_req_addr(ra[1][0]), .a_req_wdata(rd[1][0]),
        .a_rsp_valid(sv[1][0]), .a_rsp_rdata(sd[1][0]),
        .b_req_valid(rv[1][1]), .b_req_ready(rdy[1][1]), .b_req_write(rw[1][1]),
        .b_req_addr(ra[1][1]), .b_req_wdata(rd[1][1]),
        .b_rsp_valid(sv[1][1]), .b_rsp_rdata(sd[1][1]),
        .last_grant(lg[1])
    );

    // Pending request per side, held on the bus until the model grants it.
    bit         pv[2][2];
    logic       pw[2][2];
    logic [1:0] pa[2][2];
    logic [7:0] pd[2][2];

    // Reference model: plain array memory, who-went-last flag, and a queue of
    // expected responses tagged with the cycle they must appear in.
    typedef struct packed {
        int         due;
        logic [7:0] data;
    } exp_t;

    int         dep[2];
    logic [7:0] mm[2][4];
    bit         ml[2];
    exp_t       q[2][2][$];
    logic [7:0] hold[2][2];

    int cyc    = 0;
    int total  = 0;
    int passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int d, input int s,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s dut%0d side%0d @cyc%0d: got %0h, expected %0h",
                      nm, d, s, cyc, act, exp);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ml[d] = 1'b1;
            for (int i = 0; i < 4; i++) mm[d][i] = 8'h00;
            for (int s = 0; s < 2; s++) begin
                q[d][s].delete();
                hold[d][s] = 8'h00;
                pv[d][s]   = 1'b0;
                rv[d][s]   = 1'b0;
            end
        end
    endtask

    // Present pending requests, then decide the grant from the model's own
    // view, check ready/last_grant, and log the expected response.
    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 2; s++) begin
                rv[d][s] = pv[d][s];
                rw[d][s] = pw[d][s];
                ra[d][s] = pa[d][s];
                rd[d][s] = pd[d][s];
            end
        #1;
        if (!rst_n) return;
        for (int d = 0; d < 2; d++) begin
            int         g;
            logic [7:0] old;
            int         adr;
            g = -1;
            if (pv[d][0] && pv[d][1]) g = ml[d] ? 0 : 1;
            else if (pv[d][0])        g = 0;
            else if (pv[d][1])        g = 1;
            chk("last_grant", d, 0, 32'(lg[d]), 32'(ml[d]));
            for (int s = 0; s < 2; s++)
                chk("req_ready", d, s, 32'(rdy[d][s]), 32'(g == s));
            if (g >= 0) begin
                adr = int'(pa[d][g]);
                old = (adr < dep[d]) ? mm[d][adr] : 8'h00;
                if (pw[d][g] && adr < dep[d]) mm[d][adr] = pd[d][g];
                q[d][g].push_back('{due: cyc + 1, data: old});
                ml[d]    = (g == 1);
                pv[d][g] = 1'b0;
            end
        end
    endtask

    task automatic req(input int d, input int s, input logic w,
                       input logic [1:0] a, input logic [7:0] data);
        pv[d][s] = 1'b1;
        pw[d][s] = w;
        pa[d][s] = a;
        pd[d][s] = data;
    endtask

    task automatic drain();
        for (int k = 0; k < 4 && (pv[0][0] || pv[0][1] || pv[1][0] || pv[1][1]); k++)
            step();
        if (pv[0][0] || pv[0][1] || pv[1][0] || pv[1][1])
            chk("drain_timeout", 0, 0, 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Monitor: every cycle each side either owes exactly one response or
    // must stay quiet with its previous rdata held.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) chk("rst_last_grant", d, 0, 32'(lg[d]), 32'd1);
            for (int s = 0; s < 2; s++) begin
                if (!rst_n) begin
                    chk("rst_rsp_valid", d, s, 32'(sv[d][s]), 32'd0);
                    chk("rst_rsp_rdata", d, s, 32'(sd[d][s]), 32'd0);
                end else if (q[d][s].size() > 0 && q[d][s][0].due == cyc) begin
                    exp_t e;
                    e = q[d][s].pop_front();
                    chk("rsp_valid", d, s, 32'(sv[d][s]), 32'd1);
                    chk("rsp_rdata", d, s, 32'(sd[d][s]), 32'(e.data));
                    hold[d][s] = e.data;
                end else begin
                    chk("rsp_idle_valid", d, s, 32'(sv[d][s]), 32'd0);
                    chk("rsp_idle_hold", d, s, 32'(sd[d][s]), 32'(hold[d][s]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        dep[0] = 4;
        dep[1] = 3;
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 2; s++) begin
                pw[d][s] = 1'b0; pa[d][s] = 2'd0; pd[d][s] = 8'h00;
                rw[d][s] = 1'b0; ra[d][s] = 2'd0; rd[d][s] = 8'h00;
            end
        do_reset();

        // write then read same address: 0x00 then 0x5A
        req(0, 0, 1'b1, 2'd2, 8'h5A); step();
        req(0, 0, 1'b0, 2'd2, 8'h00); step();
        step();

        // reset priority: A write and B read of addr 1 in the same cycle
        do_reset();
        req(0, 0, 1'b1, 2'd1, 8'h11);
        req(0, 1, 1'b0, 2'd1, 8'h00);
        drain();

        // sustained contention, all reads: alternating grants
        for (int k = 0; k < 4; k++) begin
            if (!pv[0][0]) req(0, 0, 1'b0, 2'($urandom_range(0, 3)), 8'h00);
            if (!pv[0][1]) req(0, 1, 1'b0, 2'($urandom_range(0, 3)), 8'h00);
            step();
        end
        drain();

        // only B, three back-to-back reads
        for (int k = 0; k < 3; k++) begin
            req(0, 1, 1'b0, 2'(k), 8'h00);
            step();
        end
        step();

        // reset while A's read response is in flight
        req(0, 0, 1'b0, 2'd1, 8'h00);
        step();
        @(posedge clk);
        #1;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            req(0, 0, 1'b0, 2'(a), 8'h00);
            step();
        end
        req(0, 0, 1'b0, 2'd0, 8'h00);
        req(0, 1, 1'b0, 2'd0, 8'h00);
        drain();
        step();

        // DEPTH=3 instance: out-of-range write ignored, read returns 0
        for (int a = 0; a < 3; a++) begin
            req(1, 0, 1'b1, 2'(a), 8'($urandom));
            step();
        end
        req(1, 1, 1'b1, 2'd3, 8'hFF); step();
        req(1, 1, 1'b0, 2'd3, 8'h00); step();
        for (int a = 0; a < 3; a++) begin
            req(1, 0, 1'b0, 2'(a), 8'h00);
            step();
        end
        step();

        // randomized traffic on both instances
        for (int k = 0; k < 500; k++) begin
            for (int d = 0; d < 2; d++)
                for (int s = 0; s < 2; s++)
                    if (!pv[d][s] && $urandom_range(0, 3) != 0)
                        req(d, s, 1'($urandom_range(0, 1)),
                            2'($urandom_range(0, 3)), 8'($urandom));
            step();
        end
        drain();
        repeat (3) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regmem_rr_arbiter.md
Name: regmem_rr_arbiter

Overview:
- Owns a small register memory of DEPTH x DATA_WIDTH, which is the same shape as the 4x8 register memory the elaborator targets.
- Shares that memory between two requesters, A and B, through valid/ready request channels.
- Arbitration is round-robin. The block performs at most one access per cycle.
- Each accepted access returns a one-cycle-latency response to the requester that issued it. Both reads and writes respond.

Parameters:
- DATA_WIDTH, 8, width of each memory entry and of the data buses.
- DEPTH, 4, number of memory entries; must be at least 2.
- ADDR_WIDTH, 2, address width; must be at least clog2(DEPTH).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req_valid  in  1  requester A has an access pending.
- a_req_ready  out  1  A's access is accepted this cycle.
- a_req_write  in  1  1 = write, 0 = read.
- a_req_addr  in  ADDR_WIDTH  entry index.
- a_req_wdata  in  DATA_WIDTH  write data.
- a_rsp_valid  out  1  response pulse for A.
- a_rsp_rdata  out  DATA_WIDTH  read data, or pre-write contents for a write.
- b_req_valid, b_req_ready, b_req_write, b_req_addr, b_req_wdata, b_rsp_valid, b_rsp_rdata  same as A, for requester B.
- last_grant  out  1  0 = A was granted last, 1 = B was granted last.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - all memory entries = 0; last_grant = 1, so A has priority first.
  - a_rsp_valid = b_rsp_valid = 0; both rsp_rdata = 0.
  - any response in flight is dropped.
- Arbitration is combinational within the cycle:
  - only A valid: grant A.
  - only B valid: grant B.
  - both valid: grant the requester that is not last_grant.
  - x_req_ready = grant_x. Ready is never high without the matching valid, and the two ready outputs are mutually exclusive.
- Handshake:
  - an access is accepted when valid and ready are both high.
  - a requester must hold valid, write, addr and wdata stable until accepted. A stall has no bound beyond the round-robin guarantee.
- Round-robin update:
  - on each accepted access, last_grant <= the granted requester.
  - no change in idle cycles.
  - guarantee: with both requesters continuously valid, grants alternate A, B, A, B...; neither waits more than one cycle.
- Memory access, in the acceptance cycle:
  - old = mem[addr] is captured.
  - if write and addr < DEPTH: mem[addr] <= wdata at the same edge.
- Response:
  - the cycle after acceptance, x_rsp_valid = 1 for exactly one cycle, only for the granted requester.
  - x_rsp_rdata = old (read-before-write). The other requester's rsp_valid = 0.
  - rsp_rdata holds its last value when rsp_valid = 0.
- Latency and throughput:
  - request-to-response is 1 cycle.
  - back-to-back accepts give back-to-back responses, up to 1 access per cycle total.
- Out-of-range address (addr >= DEPTH, possible only when DEPTH is not a power of 2):
  - the write is ignored and the read data is 0.
  - the access is still accepted, responded to, and advances last_grant.
- Same address across consecutive cycles: a later access sees the earlier write, because accesses are strictly ordered.
- Reset mid-operation: a pending response is not emitted after reset release, and the memory reads 0.
- No combinational path from the rsp outputs to the req inputs.

Test Plan:
- Reset, then A writes addr 2 = 0x5A; A reads addr 2 next cycle -> first rsp rdata = 0x00; second rsp rdata = 0x5A, 1 cycle after its accept.
- A and B both valid for 4 cycles, all reads -> ready pattern A, B, A, B; last_grant toggles 0, 1, 0, 1; each rsp_valid is a single-cycle pulse to the correct side.
- A writes addr 1 = 0x11 while B is valid reading addr 1 in the same cycle -> A granted first (reset priority); B granted next cycle with rdata = 0x11.
- Only B valid for 3 cycles -> B accepted every cycle, 3 consecutive responses, a_rsp_valid stays 0, last_grant = 1.
- Assert rst_n low while A's read is in flight -> no rsp_valid after release; reading all addresses returns 0x00; first grant under contention goes to A.
- DEPTH=3 override: write 0xFF to addr 3, then read addr 3 -> both respond; read rdata = 0x00; entries 0..2 unchanged.
